// File: rtl/shift_unit_seq.sv
// Multi-cycle shifter: SLL/SRL/SRA/ROTR by a run-time amount, up to STEP bits per clock.
// Start/Done handshake; Busy stays high from the accepting edge until the edge that raises Done.
module shift_unit_seq #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = $clog2(WIDTH),
  parameter int STEP    = 1
) (
  input  logic               Clk,
  input  logic               Reset,
  input  logic               Start,
  input  logic [1:0]         Op,
  input  logic [WIDTH-1:0]   DataIn,
  input  logic [SHAMT_W-1:0] Shamt,
  output logic               Busy,
  output logic               Done,
  output logic [WIDTH-1:0]   DataOut
);

  typedef enum logic {S_IDLE, S_SHIFT} state_t;

  localparam logic [1:0] OP_SLL = 2'b00;
  localparam logic [1:0] OP_SRL = 2'b01;
  localparam logic [1:0] OP_SRA = 2'b10;

  // One extra bit so that STEP and WIDTH themselves are representable.
  localparam logic [SHAMT_W:0] STEP_W  = (SHAMT_W+1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_W = (SHAMT_W+1)'(WIDTH);

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [SHAMT_W-1:0] rem_q, rem_d;
  logic [1:0]         op_q, op_d;
  logic               done_q, done_d;
  logic [WIDTH-1:0]   dout_q, dout_d;

  logic [SHAMT_W:0]   rem_ext;
  logic [SHAMT_W:0]   k;
  logic [WIDTH-1:0]   shifted;

  // Step size is min(STEP, Rem), so the final step may be partial.
  always_comb begin
    rem_ext = {1'b0, rem_q};
    k       = (rem_ext > STEP_W) ? STEP_W : rem_ext;
    case (op_q)
      OP_SLL:  shifted = acc_q << k;
      OP_SRL:  shifted = acc_q >> k;
      OP_SRA:  shifted = WIDTH'($signed(acc_q) >>> k);
      default: shifted = (acc_q >> k) | (acc_q << (WIDTH_W - k));
    endcase
  end

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    op_d    = op_q;
    done_d  = 1'b0;
    dout_d  = dout_q;
    case (state_q)
      S_IDLE: begin
        if (Start) begin
          acc_d   = DataIn;
          rem_d   = Shamt;
          op_d    = Op;
          state_d = S_SHIFT;
        end
      end
      default: begin
        if (rem_q != '0) begin
          acc_d = shifted;
          rem_d = rem_q - k[SHAMT_W-1:0];
        end else begin
          dout_d  = acc_q;
          done_d  = 1'b1;
          state_d = S_IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= S_IDLE;
      acc_q   <= '0;
      rem_q   <= '0;
      op_q    <= '0;
      done_q  <= 1'b0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
      done_q  <= done_d;
      dout_q  <= dout_d;
    end
  end

  assign Busy    = (state_q == S_SHIFT);
  assign Done    = done_q;
  assign DataOut = dout_q;

endmodule

// File: doc/shift_unit_seq.md
Name: shift_unit_seq

Overview:
- Parametrised multi-cycle shifter: the general successor of the fixed ×4 address shifter.
- Supports logical left, logical right, arithmetic right and rotate right by a run-time shift amount.
- Shifts up to STEP bits per clock.
- Sits beside the ALU and serves sll/srl/sra/sllv/srlv/srav plus rotate, with a start/done handshake so the control unit can stall while Busy is high.

Parameters:
- WIDTH, 32, data width in bits; power of two, ≥4.
- SHAMT_W, $clog2(WIDTH), width of the shift-amount input.
- STEP, 1, maximum bits shifted per clock; power of two, 1..WIDTH.

Ports:
- Clk  input  1  system clock; all state updates on rising edge.
- Reset  input  1  synchronous, active-high reset.
- Start  input  1  request; accepted only on a rising edge where Busy=0.
- Op  input  2  00=SLL, 01=SRL, 10=SRA, 11=ROTR; sampled at acceptance.
- DataIn  input  WIDTH  operand; sampled at acceptance.
- Shamt  input  SHAMT_W  shift amount, 0..WIDTH-1; sampled at acceptance.
- Busy  output  1  high while an operation is in progress.
- Done  output  1  one-cycle pulse; DataOut is valid and updated.
- DataOut  output  WIDTH  last completed result; held until the next Done.

Behaviour:
- One clock domain.
- Reset is synchronous, active-high, and has priority over everything. On reset:
  - state=IDLE
  - Busy=0, Done=0, DataOut=0
  - internal accumulator and remaining count = 0
- States:
  - IDLE: Busy=0. If Start=1, load Acc<=DataIn, Rem<=Shamt, latch Op, go to SHIFT, Busy<=1.
  - SHIFT, Rem≠0: k=min(STEP,Rem). Acc<=Acc shifted by k per the latched Op, Rem<=Rem-k. Stay in SHIFT.
  - SHIFT, Rem=0: DataOut<=Acc, Done<=1, Busy<=0, go to IDLE.
- Done is high for exactly one cycle and is 0 in every other cycle.
- Shift rules:
  - SLL fills zeros at the LSB.
  - SRL fills zeros at the MSB.
  - SRA replicates Acc[WIDTH-1] on each step.
  - ROTR moves Acc[k-1:0] to the top.
- Latency:
  - From the accepting edge, Done is visible after edge number ceil(Shamt/STEP)+1.
  - Shamt=0 gives Done one cycle after acceptance with DataOut=DataIn.
- Busy rises on the accepting edge and falls on the edge that asserts Done.
- Back-to-back operation:
  - Busy=0 in the Done cycle, so a Start present in that cycle is accepted on the next edge.
  - This gives zero idle cycles between operations.
- Start while Busy=1: ignored; no effect on state or outputs. Op, DataIn and Shamt may change freely while busy.
- Reset mid-operation aborts the operation: Done is not produced and DataOut is cleared to 0.
- Partial last step: when Rem<STEP, only Rem bits are shifted. The result must equal the single-cycle reference shift for every STEP value.
- No combinational path from inputs to outputs; all outputs are registered.

Test Plan:
1. STEP=1, Start with Op=SLL, DataIn=0x00000001, Shamt=2 → Busy high for 3 cycles, Done after edge 3, DataOut=0x00000004 (matches the legacy ×4 behaviour).
2. STEP=1, Op=SRA, DataIn=0x80000000, Shamt=31 → Done after edge 32, DataOut=0xFFFFFFFF. Then Op=SRL with the same operands → DataOut=0x00000001.
3. STEP=4, Op=SRL, DataIn=0xF0000000, Shamt=7 → Done after edge 3, DataOut=0x01E00000. Then Op=ROTR, DataIn=0x12345678, Shamt=8 → Done after edge 3, DataOut=0x78123456.
4. Shamt=0, Op=SLL, DataIn=0xDEADBEEF → Done one cycle after acceptance, DataOut=0xDEADBEEF. A Start held high in the Done cycle (SLL 0x1 by 1) is accepted next edge, and its Done carries 0x00000002.
5. Start pulsed mid-operation with different operands → ignored; the original result is delivered with the original latency.
6. Reset asserted two cycles into an SRA by 20 → next cycle Busy=0, Done=0, DataOut=0, and no Done pulse follows. Randomised compare against a behavioural shift for all Op, Shamt and STEP∈{1,2,8,32}.
